// File: rtl/pixel_frame_sequencer.sv
// Upstream feeder for the pixel controller: buffers source bytes in a small FIFO and
// presents them tagged with channel/column/row position and frame markers.
module pixel_frame_sequencer #(
  parameter  int IMG_W      = 256,
  parameter  int IMG_H      = 128,
  parameter  int CHANNELS   = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int ROW_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       chan,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0]       CHAN_LAST = 2'(CHANNELS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_in_ready;
  logic             r_run;
  logic             r_frame_done;
  logic [15:0]      r_frame_count;
  logic [1:0]       r_chan;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic w_push;
  logic w_pop;
  logic w_out_valid;
  logic w_last_chan;
  logic w_last_col;
  logic w_last_row;
  logic w_sof_pos;
  logic w_eol_pos;
  logic w_eof_pos;

  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign w_last_chan = (r_chan == CHAN_LAST);
  assign w_last_col  = (r_col == COL_LAST);
  assign w_last_row  = (r_row == ROW_LAST);
  assign w_sof_pos   = (r_chan == 2'd0) & (r_col == '0) & (r_row == '0);
  assign w_eol_pos   = w_last_chan & w_last_col;
  assign w_eof_pos   = w_eol_pos & w_last_row;

  // Occupancy after this edge; in_ready is registered from it so it never depends on out_ready combinationally.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // FIFO pointers, occupancy and input-ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_run      <= 1'b0;
    end else if (restart) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != CNT_FULL);
      r_run      <= 1'b1;
    end
  end

  // Byte storage; contents are only observed through the valid-gated read port.
  always_ff @(posedge clk) begin
    if (w_push && !restart) begin
      r_mem[r_wr_ptr] <= in_byte;
    end
  end

  // Position counters, end-of-frame pulse and completed-frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan        <= 2'd0;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
    end else if (restart) begin
      r_chan       <= 2'd0;
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pop & w_eof_pos;
      if (w_pop) begin
        if (w_last_chan) begin
          r_chan <= 2'd0;
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row         <= '0;
              r_frame_count <= r_frame_count + 16'd1;
            end else begin
              r_row <= r_row + ROW_W'(1);
            end
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end else begin
          r_chan <= r_chan + 2'd1;
        end
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = w_out_valid;
  assign out_byte    = w_out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign chan        = r_chan;
  assign col         = r_col;
  assign row         = r_row;
  // Markers are suppressed while the block is held in reset or restart.
  assign sof         = r_run & w_sof_pos;
  assign eol         = r_run & w_eol_pos;
  assign eof         = r_run & w_eof_pos;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer: reduced 8x4x3 frame for data/tag checks,
// plus a 1x1x1 instance to exercise the 16-bit frame counter wrap.
module tb_pixel_frame_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int C  = 3;
  localparam int FB = W * H * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, restart, in_valid, in_ready, out_valid, out_ready;
  logic        sof, eol, eof, frame_done;
  logic [7:0]  in_byte, out_byte;
  logic [1:0]  chan;
  logic [2:0]  col;
  logic [1:0]  row;
  logic [15:0] frame_count;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic        d2_sof, d2_eol, d2_eof, d2_frame_done;
  logic [7:0]  d2_in_byte, d2_out_byte;
  logic [1:0]  d2_chan;
  logic [0:0]  d2_col;
  logic [0:0]  d2_row;
  logic [15:0] d2_frame_count;

  pixel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .CHANNELS(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .chan(chan), .col(col), .row(row), .sof(sof), .eol(eol), .eof(eof),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  pixel_frame_sequencer #(.IMG_W(1), .IMG_H(1), .CHANNELS(1), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_byte(d2_in_byte), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .out_byte(d2_out_byte), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .chan(d2_chan), .col(d2_col), .row(d2_row), .sof(d2_sof), .eol(d2_eol), .eof(d2_eof),
    .frame_done(d2_frame_done), .frame_count(d2_frame_count)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] ch;
    logic [2:0] co;
    logic [1:0] ro;
    logic       s;
    logic       l;
    logic       e;
  } obs_t;

  obs_t        obs_q[$];
  logic [7:0]  exp_q[$];
  int          fd_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  int          rc, rco, rro;
  logic [15:0] fc_exp;

  // Scoreboard capture: accepted input bytes and output handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && !restart) begin
      if (in_valid && in_ready) exp_q.push_back(in_byte);
      if (out_valid && out_ready) obs_q.push_back({out_byte, chan, col, row, sof, eol, eof});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic ref_reset();
    rc = 0; rco = 0; rro = 0;
  endtask

  task automatic ref_adv();
    rc++;
    if (rc == C) begin
      rc = 0; rco++;
      if (rco == W) begin
        rco = 0; rro++;
        if (rro == H) rro = 0;
      end
    end
  endtask

  function automatic obs_t model(input logic [7:0] b);
    obs_t m;
    m.b  = b;
    m.ch = 2'(rc);
    m.co = 3'(rco);
    m.ro = 2'(rro);
    m.s  = (rc == 0) && (rco == 0) && (rro == 0);
    m.l  = (rc == C - 1) && (rco == W - 1);
    m.e  = m.l && (rro == H - 1);
    return m;
  endfunction

  // One clock of stimulus; acc reports whether the input byte is taken at this edge.
  task automatic drive(input logic iv, input logic [7:0] ib, input logic ordy, output logic acc);
    in_valid  = iv;
    in_byte   = ib;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    d2_in_valid = 1'b0; d2_in_byte = 8'h3C; d2_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_byte, chan, col, row, sof, eol, eof, frame_done, frame_count} !== 37'd0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b byte=%h pos=%0d/%0d/%0d tags=%b%b%b fd=%b fc=%0d, required all zero",
               in_ready, out_valid, out_byte, chan, col, row, sof, eol, eof, frame_done, frame_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, sof} !== 3'b101) begin
      errors++; $display("FAIL ready_after_edge: got rdy=%b vld=%b sof=%b, required 1 0 1", in_ready, out_valid, sof);
    end
    fc_exp = 16'd0;
  endtask

  task automatic test_stream(input string name);
    int i, cyc, fd0;
    logic acc;
    obs_t o, m;
    ref_reset();
    i = 0; cyc = 0; fd0 = fd_cnt;
    while (obs_q.size() < FB && cyc < FB + 50) begin
      drive(i < FB, 8'(i), 1'b1, acc);
      if (acc) i++;
      cyc++;
    end
    drive(1'b0, 8'h00, 1'b1, acc);
    checks++;
    if (cyc != FB + 1) begin
      errors++; $display("FAIL %s_cycles: got %0d, required %0d", name, cyc, FB + 1);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL %s_byte: got %h, required a queued byte", name, o);
      end else begin
        m = model(exp_q.pop_front());
        if (o !== m) begin errors++; $display("FAIL %s_byte: got %h, required %h", name, o, m); end
      end
      ref_adv();
    end
    fc_exp = fc_exp + 16'd1;
    checks++;
    if (fd_cnt - fd0 != 1 || frame_count !== fc_exp) begin
      errors++; $display("FAIL %s_frame: got pulses=%0d count=%0d, required 1 %0d", name, fd_cnt - fd0, frame_count, fc_exp);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic acc;
    obs_t o, m;
    logic [7:0] base;
    base = 8'hA0;
    k = 0;
    for (int n = 0; n < 8; n++) begin
      drive(k < 6, base + 8'(k), 1'b0, acc);
      if (acc) k++;
    end
    checks++;
    if (k != 4 || {in_ready, out_valid, out_byte} !== {1'b0, 1'b1, 8'hA0}) begin
      errors++;
      $display("FAIL full_hold: got acc=%0d rdy=%b vld=%b byte=%h, required 4 0 1 a0", k, in_ready, out_valid, out_byte);
    end
    drive(1'b1, base + 8'(k), 1'b1, acc);
    checks++;
    if (acc || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_release: got acc=%b rdy=%b, required 0 1", acc, in_ready);
    end
    for (int n = 0; n < 20 && obs_q.size() < 6; n++) begin
      drive(k < 6, base + 8'(k), 1'b1, acc);
      if (acc) k++;
    end
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL bp_count: got %0d, required 6", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL bp_order: got %h, required a queued byte", o);
      end else begin
        m = model(exp_q.pop_front());
        if (o !== m) begin errors++; $display("FAIL bp_order: got %h, required %h", o, m); end
      end
      ref_adv();
    end
  endtask

  task automatic test_restart();
    int i, fd0;
    logic acc;
    obs_t o, m;
    restart = 1'b1;
    drive(1'b0, 8'h00, 1'b0, acc);
    restart = 1'b0;
    ref_reset(); exp_q.delete(); obs_q.delete();
    fd0 = fd_cnt; i = 0;
    for (int n = 0; n < 200 && obs_q.size() < 50; n++) begin
      drive(i < 50, 8'(i * 7), 1'b1, acc);
      if (acc) i++;
    end
    for (int n = 0; n < 3; n++) drive(1'b1, 8'hC0 + 8'(n), 1'b0, acc);
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'hC0}) begin
      errors++; $display("FAIL restart_queued: got vld=%b byte=%h, required 1 c0", out_valid, out_byte);
    end
    restart = 1'b1;
    drive(1'b1, 8'h77, 1'b1, acc);
    restart = 1'b0;
    checks++;
    if ({out_valid, in_ready, chan, col, row, frame_done, frame_count} !== {1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, fc_exp}) begin
      errors++;
      $display("FAIL restart_clear: got vld=%b rdy=%b pos=%0d/%0d/%0d fd=%b fc=%0d, required 0 0 0/0/0 0 %0d",
               out_valid, in_ready, chan, col, row, frame_done, frame_count, fc_exp);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL restart_pre: got %h, required a queued byte", o);
      end else begin
        m = model(exp_q.pop_front());
        if (o !== m) begin errors++; $display("FAIL restart_pre: got %h, required %h", o, m); end
      end
      ref_adv();
    end
    exp_q.delete();
    ref_reset();
    drive(1'b0, 8'h00, 1'b1, acc);
    checks++;
    if ({in_ready, sof} !== 2'b11) begin
      errors++; $display("FAIL restart_idle: got rdy=%b sof=%b, required 1 1", in_ready, sof);
    end
    drive(1'b1, 8'h5A, 1'b1, acc);
    drive(1'b0, 8'h00, 1'b1, acc);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL restart_next: got %0d outputs, required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      m = model(exp_q.pop_front());
      if (o !== m || m.s !== 1'b1) begin errors++; $display("FAIL restart_next: got %h, required %h", o, m); end
      ref_adv();
    end
    checks++;
    if (frame_count !== fc_exp || fd_cnt != fd0) begin
      errors++; $display("FAIL restart_count: got fc=%0d pulses=%0d, required %0d 0", frame_count, fd_cnt - fd0, fc_exp);
    end
  endtask

  task automatic test_random();
    int pushed, cyc, fd0;
    logic acc, prev_eof;
    obs_t o, m;
    restart = 1'b1;
    drive(1'b0, 8'h00, 1'b0, acc);
    restart = 1'b0;
    ref_reset(); exp_q.delete(); obs_q.delete();
    pushed = 0; cyc = 0; fd0 = fd_cnt;
    while (obs_q.size() < 2 * FB && cyc < 4000) begin
      drive((pushed < 2 * FB) && ($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 1) == 1), acc);
      if (acc) pushed++;
      cyc++;
    end
    drive(1'b0, 8'h00, 1'b0, acc);
    checks++;
    if (obs_q.size() != 2 * FB) begin
      errors++; $display("FAIL random_timeout: got %0d outputs, required %0d", obs_q.size(), 2 * FB);
    end
    prev_eof = 1'b0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL random_byte: got %h, required a queued byte", o);
      end else begin
        m = model(exp_q.pop_front());
        if (o !== m || (prev_eof && !o.s)) begin errors++; $display("FAIL random_byte: got %h, required %h", o, m); end
      end
      prev_eof = o.e;
      ref_adv();
    end
    fc_exp = fc_exp + 16'd2;
    checks++;
    if (fd_cnt - fd0 != 2 || frame_count !== fc_exp) begin
      errors++; $display("FAIL random_frames: got pulses=%0d fc=%0d, required 2 %0d", fd_cnt - fd0, frame_count, fc_exp);
    end
  endtask

  task automatic test_reset_midframe();
    int i;
    logic acc;
    obs_t o, m;
    ref_reset(); i = 0;
    for (int n = 0; n < 200 && obs_q.size() < 60; n++) begin
      drive(i < FB, 8'(i + 9), 1'b1, acc);
      if (acc) i++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_byte, chan, col, row, sof, eol, eof, frame_done, frame_count} !== 37'd0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b vld=%b byte=%h pos=%0d/%0d/%0d tags=%b%b%b fc=%0d, required all zero",
               in_ready, out_valid, out_byte, chan, col, row, sof, eol, eof, frame_count);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL midframe_byte: got %h, required a queued byte", o);
      end else begin
        m = model(exp_q.pop_front());
        if (o !== m) begin errors++; $display("FAIL midframe_byte: got %h, required %h", o, m); end
      end
      ref_adv();
    end
    exp_q.delete();
    fc_exp = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_stream("after_reset");
  endtask

  task automatic test_wrap();
    int n, cyc, bad;
    logic [15:0] fc_before;
    n = 0; cyc = 0; bad = 0; fc_before = 16'd0;
    d2_in_valid = 1'b1; d2_out_ready = 1'b1;
    while (n < 65536 && cyc < 70000) begin
      @(negedge clk);
      if (d2_out_valid && d2_out_ready) begin
        n++;
        if (!(d2_sof && d2_eol && d2_eof) || d2_out_byte !== 8'h3C || {d2_chan, d2_col, d2_row} !== 4'd0 || !d2_in_ready) bad++;
        if (n == 65536) fc_before = d2_frame_count;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    d2_in_valid = 1'b0; d2_out_ready = 1'b0;
    checks++;
    if (n != 65536 || bad != 0) begin
      errors++; $display("FAIL wrap_stream: got %0d frames %0d bad, required 65536 0", n, bad);
    end
    checks++;
    if (fc_before !== 16'hFFFF || d2_frame_count !== 16'd0 || d2_frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: got before=%h after=%h fd=%b, required ffff 0000 1", fc_before, d2_frame_count, d2_frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_stream("stream");
    test_backpressure();
    test_restart();
    test_random();
    test_reset_midframe();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
